// File: rtl/dlfloat_dot_if.sv
// Beat input and result output bundle for the DLFloat16 dot-product engine.
// The engine takes the slave modport; the traffic source/sink takes master.
interface dlfloat_dot_if #(
  parameter int LANES = 1,
  parameter int CNT_W = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [16*LANES-1:0]    in_a;
  logic [16*LANES-1:0]    in_b;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [15:0]            out_data;
  logic                   out_special;
  logic [CNT_W-1:0]       out_len;

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_special, out_len
  );

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_special, out_len
  );
endinterface

// File: rtl/dlfloat_dot_engine.sv
// Pipelined DLFloat16 dot-product engine: multiply (S1), lane tree (S2), accumulate (S3),
// truncating arithmetic, with a single result register that back-pressures the whole pipe.
module dlfloat_dot_engine #(
  parameter int LANES = 1,
  parameter int CNT_W = 8
) (
  input logic          clk,
  input logic          rst,
  dlfloat_dot_if.slave dot
);
  localparam logic [15:0] SPECIAL = 16'hFFFF;

  function automatic logic [15:0] dl_mul(input logic [15:0] a, input logic [15:0] b);
    logic [19:0]       prod;
    logic signed [8:0] e;
    logic [8:0]        mant;
    dl_mul = 16'h0000;
    prod   = 20'({1'b1, a[8:0]}) * 20'({1'b1, b[8:0]});
    e      = $signed(9'(a[14:9]) + 9'(b[14:9]) + 9'(prod[19]) - 9'd31);
    mant   = prod[19] ? prod[18:10] : prod[17:9];
    if (a == SPECIAL || b == SPECIAL)      dl_mul = SPECIAL;
    else if (a[14:9] == 6'd0 || b[14:9] == 6'd0) dl_mul = 16'h0000;
    else if (e > 9'sd62)                   dl_mul = SPECIAL;
    else if (e < 9'sd1)                    dl_mul = 16'h0000;
    else                                   dl_mul = {a[15] ^ b[15], e[5:0], mant};
  endfunction

  // Three extra bits plus a sticky that is subtracted on effective subtraction give
  // the exact floor of the magnitude, so dropping low bits truncates toward zero.
  function automatic logic [15:0] dl_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0]       hi;
    logic [15:0]       lo;
    logic [5:0]        d;
    logic [25:0]       shifted;
    logic [12:0]       bi;
    logic              sticky;
    logic [13:0]       s;
    logic [3:0]        p;
    logic [13:0]       norm;
    logic signed [8:0] e;
    dl_add = 16'h0000;
    if (x[14:0] >= y[14:0]) begin
      hi = x;
      lo = y;
    end else begin
      hi = y;
      lo = x;
    end
    d       = hi[14:9] - lo[14:9];
    shifted = {1'b1, lo[8:0], 16'b0} >> d;
    bi      = shifted[25:13];
    sticky  = |shifted[12:0];
    if (d > 6'd25) begin
      bi     = '0;
      sticky = 1'b1;
    end
    if (hi[15] == lo[15]) s = {2'b01, hi[8:0], 3'b000} + {1'b0, bi};
    else                  s = {2'b01, hi[8:0], 3'b000} - {1'b0, bi} - {13'b0, sticky};
    p = '0;
    for (int i = 0; i < 14; i++) begin
      if (s[i]) p = 4'(i);
    end
    norm = s << (4'd13 - p);
    e    = $signed(9'(hi[14:9]) + 9'(p) - 9'd12);
    if (x == SPECIAL || y == SPECIAL) dl_add = SPECIAL;
    else if (x[14:9] == 6'd0)         dl_add = (y[14:9] == 6'd0) ? 16'h0000 : y;
    else if (y[14:9] == 6'd0)         dl_add = x;
    else if (s == 14'd0)              dl_add = 16'h0000;
    else if (e > 9'sd62)              dl_add = SPECIAL;
    else if (e < 9'sd1)               dl_add = 16'h0000;
    else                              dl_add = {hi[15], e[5:0], norm[12:4]};
  endfunction

  logic             stall;
  logic             accept;
  logic [15:0]      prod_d    [LANES];
  logic [15:0]      s1_prod_q [LANES];
  logic             s1_valid_q;
  logic             s1_last_q;
  logic             s2_valid_q;
  logic             s2_last_q;
  logic [15:0]      lane_sum_d;
  logic [15:0]      s2_sum_q;
  logic [15:0]      acc_q;
  logic [15:0]      acc_sum_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc_d;
  logic             out_valid_q;
  logic [15:0]      out_data_q;
  logic [CNT_W-1:0] out_len_q;

  assign stall        = out_valid_q & ~dot.out_ready;
  assign dot.in_ready = ~rst & ~stall;
  assign accept       = dot.in_valid & dot.in_ready;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_mul
      assign prod_d[gi] = dl_mul(dot.in_a[16*gi +: 16], dot.in_b[16*gi +: 16]);
    end
  endgenerate

  generate
    if (LANES == 1) begin : g_tree1
      assign lane_sum_d = s1_prod_q[0];
    end else if (LANES == 2) begin : g_tree2
      assign lane_sum_d = dl_add(s1_prod_q[0], s1_prod_q[1]);
    end else begin : g_tree4
      assign lane_sum_d = dl_add(dl_add(s1_prod_q[0], s1_prod_q[1]),
                                 dl_add(s1_prod_q[2], s1_prod_q[3]));
    end
  endgenerate

  assign acc_sum_d = dl_add(acc_q, s2_sum_q);
  assign cnt_inc_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // Stage payloads are qualified by their valid bits and need no reset.
  always_ff @(posedge clk) begin
    if (!stall) begin
      if (accept) begin
        s1_prod_q <= prod_d;
        s1_last_q <= dot.in_last;
      end
      if (s1_valid_q) begin
        s2_sum_q  <= lane_sum_d;
        s2_last_q <= s1_last_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      acc_q       <= 16'h0000;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_len_q   <= '0;
    end else if (!stall) begin
      s1_valid_q  <= accept;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= 1'b0;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          out_data_q  <= acc_sum_d;
          out_len_q   <= cnt_inc_d;
          out_valid_q <= 1'b1;
          acc_q       <= 16'h0000;
          cnt_q       <= '0;
        end else begin
          acc_q <= acc_sum_d;
          cnt_q <= cnt_inc_d;
        end
      end
    end
  end

  assign dot.out_valid   = out_valid_q;
  assign dot.out_data    = out_data_q;
  assign dot.out_len     = out_len_q;
  assign dot.out_special = (out_data_q == SPECIAL);
endmodule

// File: tb/tb_dlfloat_dot_engine.sv
// Bench for dlfloat_dot_engine (LANES=4): directed vectors plus random vectors scored
// against an exact-arithmetic reference that truncates each operation toward zero.
module tb_dlfloat_dot_engine;
  localparam int LANES = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dlfloat_dot_if #(.LANES(LANES), .CNT_W(CNT_W)) dot_if ();

  dlfloat_dot_engine #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .dot(dot_if)
  );

  typedef struct {
    logic [15:0]      data;
    logic [CNT_W-1:0] len;
  } exp_t;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   results = 0;
  int   bp_mode = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  // Reference: value = mag * 2^u exactly, truncated to a 10-bit significand.
  function automatic logic [15:0] m_round(input logic neg, input logic [127:0] mag, input int u);
    int p;
    int e;
    logic [127:0] m;
    p = -1;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    if (p < 0) return 16'h0000;
    e = p + u + 31;
    if (e > 62) return 16'hFFFF;
    if (e < 1) return 16'h0000;
    m = (p >= 9) ? (mag >> (p - 9)) : (mag << (9 - p));
    return {neg, e[5:0], m[8:0]};
  endfunction

  function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
    if (a[14:9] == 6'd0 || b[14:9] == 6'd0) return 16'h0000;
    return m_round(a[15] ^ b[15], 128'({1'b1, a[8:0]}) * 128'({1'b1, b[8:0]}),
                   int'(a[14:9]) + int'(b[14:9]) - 80);
  endfunction

  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
    logic signed [127:0] va;
    logic signed [127:0] vb;
    logic signed [127:0] s;
    if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
    if (a[14:9] == 6'd0) return (b[14:9] == 6'd0) ? 16'h0000 : b;
    if (b[14:9] == 6'd0) return a;
    va = 128'({1'b1, a[8:0]}) << (int'(a[14:9]) - 1);
    vb = 128'({1'b1, b[8:0]}) << (int'(b[14:9]) - 1);
    if (a[15]) va = -va;
    if (b[15]) vb = -vb;
    s = va + vb;
    return m_round(s < 0, (s < 0) ? -s : s, -39);
  endfunction

  function automatic logic [15:0] m_beat(input logic [63:0] a, input logic [63:0] b);
    logic [15:0] p [4];
    for (int i = 0; i < 4; i++) p[i] = m_mul(a[16*i +: 16], b[16*i +: 16]);
    return m_add(m_add(p[0], p[1]), m_add(p[2], p[3]));
  endfunction

  function automatic logic [15:0] rnd_op();
    int r;
    int e;
    r = $urandom_range(0, 999);
    if (r < 40) return 16'h0000;
    if (r == 40) return 16'hFFFF;
    if (r < 550) e = $urandom_range(28, 34);
    else if (r < 950) e = $urandom_range(15, 47);
    else e = $urandom_range(1, 62);
    return {1'($urandom_range(0, 1)), 6'(e), 9'($urandom_range(0, 511))};
  endfunction

  function automatic logic [63:0] rnd_beat();
    return {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
  endfunction

  function automatic logic [63:0] ln0(input logic [15:0] v);
    return {48'h0, v};
  endfunction

  task automatic push_exp(input logic [15:0] data, input int len);
    exp_t e;
    e.data = data;
    e.len  = CNT_W'((len > 255) ? 255 : len);
    exp_q.push_back(e);
  endtask

  task automatic send_beat(input logic [63:0] a, input logic [63:0] b, input logic last);
    int   waited;
    logic took;
    waited = 0;
    took   = 1'b0;
    dot_if.in_valid = 1'b1;
    dot_if.in_a     = a;
    dot_if.in_b     = b;
    dot_if.in_last  = last;
    while (!took && waited < 500) begin
      @(negedge clk);
      took = dot_if.in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!took) check_val("accept_timeout", 32'(took), 32'd1);
    dot_if.in_valid = 1'b0;
    dot_if.in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_val("drain_pending", exp_q.size(), 0);
  endtask

  task automatic run_random_vec(input int nbeats);
    logic [63:0] av[$];
    logic [63:0] bv[$];
    logic [63:0] a;
    logic [63:0] b;
    logic [15:0] acc;
    acc = 16'h0000;
    for (int i = 0; i < nbeats; i++) begin
      a = rnd_beat();
      b = rnd_beat();
      av.push_back(a);
      bv.push_back(b);
      acc = m_add(acc, m_beat(a, b));
    end
    push_exp(acc, nbeats);
    for (int i = 0; i < nbeats; i++) send_beat(av[i], bv[i], i == nbeats - 1);
  endtask

  // out_ready: 0 = always ready, 1 = held low, 2 = random.
  initial begin
    dot_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode == 0)      dot_if.out_ready = 1'b1;
      else if (bp_mode == 1) dot_if.out_ready = 1'b0;
      else                   dot_if.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Result scoreboard and handshake rules, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (dot_if.out_valid && !dot_if.out_ready) check_val("in_ready_stall", dot_if.in_ready, 0);
      else check_val("in_ready_free", dot_if.in_ready, 1);
      if (exp_q.size() == 0) begin
        check_val("out_valid_idle", dot_if.out_valid, 0);
      end else if (dot_if.out_valid) begin
        check_val("out_data", dot_if.out_data, exp_q[0].data);
        check_val("out_special", dot_if.out_special, 32'(exp_q[0].data == 16'hFFFF));
        check_val("out_len", dot_if.out_len, exp_q[0].len);
        if (dot_if.out_ready) begin
          results++;
          $display("result %0d data=%h special=%0d len=%0d", results, dot_if.out_data,
                   dot_if.out_special, dot_if.out_len);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    dot_if.in_valid = 1'b0;
    dot_if.in_a     = '0;
    dot_if.in_b     = '0;
    dot_if.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", dot_if.out_valid, 0);
    check_val("rst_out_data", dot_if.out_data, 0);
    check_val("rst_out_special", dot_if.out_special, 0);
    check_val("rst_out_len", dot_if.out_len, 0);
    check_val("rst_in_ready", dot_if.in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1.0*2.0 twice -> 4.0, plus the two-edge latency of the last beat
    push_exp(16'h4200, 2);
    send_beat(ln0(16'h3E00), ln0(16'h4000), 1'b0);
    send_beat(ln0(16'h3E00), ln0(16'h4000), 1'b1);
    @(negedge clk);
    check_val("lat_edge_k", dot_if.out_valid, 0);
    @(negedge clk);
    check_val("lat_edge_k1", dot_if.out_valid, 0);
    @(negedge clk);
    check_val("lat_edge_k2", dot_if.out_valid, 1);
    drain();

    push_exp(16'h4300, 1);
    send_beat({4{16'h3E00}}, {4{16'h3F00}}, 1'b1);
    push_exp(16'h0000, 2);
    send_beat(ln0(16'h4000), ln0(16'h3E00), 1'b0);
    send_beat(ln0(16'hC000), ln0(16'h3E00), 1'b1);
    push_exp(16'hFFFF, 3);
    send_beat({16'h3E00, 16'h3F00, 16'hFFFF, 16'h4000}, {4{16'h3E00}}, 1'b0);
    send_beat({4{16'h3F00}}, {4{16'h3E00}}, 1'b0);
    send_beat({4{16'h4000}}, {4{16'h3E00}}, 1'b1);
    drain();

    // Hold out_ready low while a result waits and the next vector is offered.
    bp_mode = 1;
    push_exp(16'h4200, 2);
    send_beat(ln0(16'h3E00), ln0(16'h4000), 1'b0);
    send_beat(ln0(16'h3E00), ln0(16'h4000), 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dot_if.out_valid && n < 20);
    check_val("bp_out_valid", dot_if.out_valid, 1);
    push_exp(16'h4100, 1);
    fork
      send_beat(ln0(16'h4000), ln0(16'h3F00), 1'b1);
      begin
        repeat (4) @(negedge clk);
        bp_mode = 0;
      end
    join
    drain();

    // Reset with a partial vector in flight.
    send_beat(ln0(16'h4400), ln0(16'h4400), 1'b0);
    send_beat(ln0(16'h4400), ln0(16'h4400), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_mid_in_ready", dot_if.in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check_val("rst_mid_out_valid", dot_if.out_valid, 0);
    check_val("rst_mid_out_len", dot_if.out_len, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_exp(16'h3E00, 1);
    send_beat(ln0(16'h3E00), ln0(16'h3E00), 1'b1);
    drain();

    for (int v = 0; v < 15; v++) run_random_vec($urandom_range(1, 5));
    drain();
    bp_mode = 2;
    for (int v = 0; v < 15; v++) run_random_vec($urandom_range(1, 5));
    drain();
    bp_mode = 0;

    // Beat counter saturation on a 300-beat vector.
    push_exp(16'h3E00, 300);
    for (int i = 0; i < 300; i++)
      send_beat(ln0((i == 0) ? 16'h3E00 : 16'h0000), ln0(16'h3E00), i == 299);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
